// File: rtl/icache_dm_pkg.sv
// Shared instruction-cache types: machine word, frame layout, controller states.
package icache_dm_pkg;

    typedef logic [31:0] word_t;

    // Geometry of the default 16-set configuration.
    localparam int IIDX_W = 4;
    localparam int ITAG_W = 30 - IIDX_W;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally in
// IDLE; a miss parks the word address, fetches one word in FILL, installs it
// and the fetch replays as a hit in the following IDLE cycle.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  iwait,
    input  word_t iload,
    output logic  iREN,
    output word_t iaddr,
    output word_t hit_count,
    output word_t miss_count
);

    icache_state_t state_q, state_d;
    logic [29:0]   miss_addr_q, miss_addr_d;

    // Frame storage kept as parallel arrays so the tag width follows SETS.
    logic              valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS];
    word_t             data_q  [SETS];

    word_t hit_count_q, miss_count_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             unused_offset;

    assign idx           = imemaddr[IDX_W+1:2];
    assign tag           = imemaddr[31:IDX_W+2];
    assign hit           = imemREN & valid_q[idx] & (tag_q[idx] == tag);
    assign fill_idx      = miss_addr_q[IDX_W-1:0];
    assign fill_tag      = miss_addr_q[29:IDX_W];
    assign unused_offset = ^imemaddr[1:0];

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // State register and the parked miss address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Next state: a lookup miss starts a fill; a fill ends when memory answers.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        if (state_q == IDLE) begin
            if (imemREN && !hit) begin
                state_d     = FILL;
                miss_addr_d = imemaddr[31:2];
            end
        end else begin
            if (!iwait) begin
                state_d = IDLE;
            end
        end
    end

    // Outputs: memory side driven only from registers; hit path only in IDLE.
    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        if (state_q == IDLE) begin
            ihit     = hit;
            imemload = hit ? data_q[idx] : '0;
        end else begin
            iREN  = 1'b1;
            iaddr = {miss_addr_q, 2'b00};
        end
    end

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == IDLE && imemREN) begin
            if (hit) begin
                hit_count_q  <= hit_count_q + 32'd1;
            end else begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    // Frame array: cleared by reset, written once when a fill completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 1'b0;
                tag_q[s]   <= '0;
                data_q[s]  <= '0;
            end
        end else if (state_q == FILL && !iwait) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= fill_tag;
            data_q[fill_idx]  <= iload;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed cycle table followed by randomized traffic
// checked against an abstract cache model.
module tb_icache_dm;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iwait = 1'b1;
    logic [31:0] iload = '0;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_dm #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iwait      (iwait),
        .iload      (iload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          chk;
        bit          rst;
        bit          ren;
        logic [31:0] addr;
        bit          wt;
        logic [31:0] ld;
        bit          e_hit;
        logic [31:0] e_load;
        bit          e_iren;
        logic [31:0] e_iaddr;
        logic [31:0] e_hc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit chk, input bit rst, input bit ren, input logic [31:0] addr,
                       input bit wt, input logic [31:0] ld, input bit e_hit,
                       input logic [31:0] e_load, input bit e_iren, input logic [31:0] e_iaddr,
                       input logic [31:0] e_hc, input logic [31:0] e_mc);
        vec_t v;
        v.chk = chk; v.rst = rst; v.ren = ren; v.addr = addr; v.wt = wt; v.ld = ld;
        v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
        v.e_hc = e_hc; v.e_mc = e_mc;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tagname, input bit e_hit, input logic [31:0] e_load,
                             input bit e_iren, input logic [31:0] e_iaddr,
                             input logic [31:0] e_hc, input logic [31:0] e_mc);
        check({tagname, ".ihit"},       {31'd0, ihit}, {31'd0, e_hit});
        check({tagname, ".imemload"},   imemload,      e_load);
        check({tagname, ".iREN"},       {31'd0, iREN}, {31'd0, e_iren});
        check({tagname, ".iaddr"},      iaddr,         e_iaddr);
        check({tagname, ".hit_count"},  hit_count,     e_hc);
        check({tagname, ".miss_count"}, miss_count,    e_mc);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Abstract cache model: 16 frames addressed by word address modulo 16.
    bit          m_v [16];
    logic [25:0] m_t [16];
    logic [31:0] m_d [16];
    bit          m_fill;
    logic [31:0] m_maddr;
    logic [31:0] m_hc, m_mc;

    initial begin
        // Reset and first miss with three wait cycles.
        add(0,1,0,32'h0,1,32'h0,                 0,32'h0,0,32'h0,0,0);
        add(1,0,0,32'h0,1,32'h0,                 0,32'h0,0,32'h0,0,0);
        add(1,0,1,32'h40,1,32'h0,                0,32'h0,0,32'h0,0,0);
        add(1,0,1,32'h40,1,32'h0,                0,32'h0,1,32'h40,0,1);
        add(1,0,1,32'h40,1,32'h0,                0,32'h0,1,32'h40,0,1);
        add(1,0,1,32'h40,1,32'h0,                0,32'h0,1,32'h40,0,1);
        add(1,0,1,32'h40,0,32'h2408_0005,        0,32'h0,1,32'h40,0,1);
        add(1,0,1,32'h40,1,32'h0,                1,32'h2408_0005,0,32'h0,0,1);
        // Repeated hits.
        for (int k = 1; k <= 4; k++)
            add(1,0,1,32'h40,1,32'h0,            1,32'h2408_0005,0,32'h0,k,1);
        // Fetch disabled on a cached address.
        add(1,0,0,32'h40,1,32'h0,                0,32'h0,0,32'h0,5,1);
        add(1,0,0,32'h40,1,32'h0,                0,32'h0,0,32'h0,5,1);
        // Conflict in index 0, minimum miss penalty.
        add(1,0,1,32'h80,1,32'h0,                0,32'h0,0,32'h0,5,1);
        add(1,0,1,32'h80,0,32'hDEAD_BEEF,        0,32'h0,1,32'h80,5,2);
        add(1,0,1,32'h80,1,32'h0,                1,32'hDEAD_BEEF,0,32'h0,5,2);
        add(1,0,1,32'h40,1,32'h0,                0,32'h0,0,32'h0,6,2);
        add(1,0,1,32'h40,0,32'h2408_0005,        0,32'h0,1,32'h40,6,3);
        add(1,0,1,32'h40,1,32'h0,                1,32'h2408_0005,0,32'h0,6,3);
        // Address changes during fill.
        add(1,0,1,32'h100,1,32'h0,               0,32'h0,0,32'h0,7,3);
        add(1,0,1,32'h104,1,32'h0,               0,32'h0,1,32'h100,7,4);
        add(1,0,1,32'h104,0,32'h1111_1111,       0,32'h0,1,32'h100,7,4);
        add(1,0,1,32'h104,1,32'h0,               0,32'h0,0,32'h0,7,4);
        add(1,0,1,32'h104,0,32'h2222_2222,       0,32'h0,1,32'h104,7,5);
        add(1,0,1,32'h104,1,32'h0,               1,32'h2222_2222,0,32'h0,7,5);
        // Re-cache 0x40, then reset in the middle of a fill.
        add(1,0,1,32'h40,1,32'h0,                0,32'h0,0,32'h0,8,5);
        add(1,0,1,32'h40,0,32'h2408_0005,        0,32'h0,1,32'h40,8,6);
        add(1,0,1,32'h40,1,32'h0,                1,32'h2408_0005,0,32'h0,8,6);
        add(1,0,1,32'h80,1,32'h0,                0,32'h0,0,32'h0,9,6);
        add(1,0,1,32'h80,1,32'h0,                0,32'h0,1,32'h80,9,7);
        add(1,1,1,32'h80,1,32'h0,                0,32'h0,1,32'h80,9,7);
        add(1,0,0,32'h40,1,32'h0,                0,32'h0,0,32'h0,0,0);
        add(1,0,1,32'h40,1,32'h0,                0,32'h0,0,32'h0,0,0);
        add(1,0,1,32'h40,1,32'h0,                0,32'h0,1,32'h40,0,1);
        add(1,0,1,32'h40,0,32'h2408_0005,        0,32'h0,1,32'h40,0,1);
        add(1,0,1,32'h40,1,32'h0,                1,32'h2408_0005,0,32'h0,0,1);

        @(posedge CLK);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            RST      = vq[i].rst;
            imemREN  = vq[i].ren;
            imemaddr = vq[i].addr;
            iwait    = vq[i].wt;
            iload    = vq[i].ld;
            @(negedge CLK);
            if (vq[i].chk)
                check_all($sformatf("vec%0d", i), vq[i].e_hit, vq[i].e_load, vq[i].e_iren,
                          vq[i].e_iaddr, vq[i].e_hc, vq[i].e_mc);
            @(posedge CLK);
            #1;
        end

        // Randomized phase: start from a reset so the model and DUT agree.
        RST = 1'b1; imemREN = 1'b0; iwait = 1'b1;
        @(posedge CLK);
        #1;
        for (int s = 0; s < 16; s++) begin
            m_v[s] = 1'b0; m_t[s] = '0; m_d[s] = '0;
        end
        m_fill = 1'b0; m_maddr = '0; m_hc = '0; m_mc = '0;

        for (int c = 0; c < 3000; c++) begin
            bit          r_rst, r_ren, r_wt, e_hit;
            logic [31:0] r_addr, t, e_load, e_iaddr;
            int          ix;
            r_rst = ($urandom_range(0, 149) == 0);
            r_ren = ($urandom_range(0, 3) != 0);
            t     = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) t = $urandom & 32'h03FF_FFFF;
            r_addr = {t[25:0], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            r_wt   = ($urandom_range(0, 2) != 0);
            RST      = r_rst;
            imemREN  = r_ren;
            imemaddr = r_addr;
            iwait    = r_wt;
            iload    = m_fill ? memfn(m_maddr) : $urandom;
            @(negedge CLK);
            ix      = (r_addr / 4) % 16;
            e_hit   = !m_fill && r_ren && m_v[ix] && (m_t[ix] == r_addr[31:6]);
            e_load  = e_hit ? m_d[ix] : 32'h0;
            e_iaddr = m_fill ? m_maddr : 32'h0;
            check_all($sformatf("rnd%0d", c), e_hit, e_load, m_fill, e_iaddr, m_hc, m_mc);
            if (r_rst) begin
                for (int s = 0; s < 16; s++) m_v[s] = 1'b0;
                m_fill = 1'b0; m_hc = '0; m_mc = '0;
            end else if (!m_fill) begin
                if (r_ren) begin
                    if (e_hit) m_hc = m_hc + 1;
                    else begin
                        m_mc    = m_mc + 1;
                        m_fill  = 1'b1;
                        m_maddr = r_addr & 32'hFFFF_FFFC;
                    end
                end
            end else if (!r_wt) begin
                ix       = (m_maddr / 4) % 16;
                m_v[ix]  = 1'b1;
                m_t[ix]  = m_maddr[31:6];
                m_d[ix]  = memfn(m_maddr);
                m_fill   = 1'b0;
            end
            @(posedge CLK);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the pipeline fetch stage (`imemREN`/`imemaddr` -> `ihit`/`imemload`) and the memory controller instruction port (`iREN`/`iaddr` <- `iwait`/`iload`). Hits return in the same cycle. A miss fetches one word from memory, installs it, and replays as a hit on the following cycle. Hit and miss counters are exported for performance debug.

## Interface
- `SETS`, 16: number of frames; power of two, >= 2.
- `IDX_W`, `$clog2(SETS)`: index width (derived, not overridden).
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: synchronous reset, active-high. One clock; reset is synchronous and active-high.
- `imemREN`  in  1: fetch request from datapath.
- `imemaddr`  in  32: fetch byte address; bits [1:0] ignored.
- `ihit`  out  1: `imemload` valid this cycle.
- `imemload`  out  32: instruction word.
- `iwait`  in  1: memory busy; `iload` valid in the cycle `iwait`==0 while `iREN`==1.
- `iload`  in  32: memory read data.
- `iREN`  out  1: memory read request.
- `iaddr`  out  32: memory read address, word-aligned.
- `hit_count`  out  32: fetches served as hits since reset.
- `miss_count`  out  32: misses since reset.

## Operation
- Address split: offset [1:0]; index [IDX_W+1:2]; tag [31:IDX_W+2], `TAG_W`=30-IDX_W.
- Frame contents: `valid`, `tag`, `data`. Frames reset to valid=0, tag=0, data=0.
- States: IDLE, FILL.
- IDLE:
  - `hit` = `imemREN` & frame[idx].valid & tag match. `ihit`=`hit`, `imemload`=frame[idx].data, else 0.
  - On `imemREN` & !`hit`: latch `imemaddr` into `miss_addr`, increment `miss_count`, go to FILL.
  - `imemREN`=0: no action, `ihit`=0, `imemload`=0.
- FILL:
  - `iREN`=1, `iaddr`={`miss_addr`[31:2],2'b00}, `ihit`=0.
  - When `iwait`=0, write frame[`miss_addr` idx] with valid=1, tag, and data=`iload`, then go to IDLE.
  - When `iwait`=1, hold.
- `hit_count` increments on every IDLE cycle with `hit`=1, including the replay hit after a fill.
- Both counters wrap modulo 2^32.
- `imemaddr` changing during FILL has no effect. The fill completes for `miss_addr`, and the new address is looked up in IDLE afterwards.
- `imemREN` dropping during FILL (halt) does not abort the fill. The fill completes and the state returns to IDLE.
- Conflict: a fill overwrites a valid frame with a different tag unconditionally.
- No write port. No invalidate except reset.

## Timing
- Reset (`RST`=1 at an edge) sets:
  - state=IDLE, all frames invalid.
  - Both counters = 0.
  - Outputs next cycle: `iREN`=0, `iaddr`=0, `ihit`=0, `imemload`=0.
- Reset during FILL aborts the fill. `iREN` drops in the cycle after the edge and no frame is written.
- Hit latency: 0 cycles, combinational from `imemaddr`.
- Miss latency: cycle 0 is lookup and miss, and IDLE->FILL at the edge. `iREN` is high from cycle 1 until the edge closing the cycle in which `iwait`=0. The replay hit occurs in the following cycle.
- Minimum miss penalty with `iwait`=0 immediately: `ihit` on cycle 2.
- Simultaneous fill-complete edge and a new lookup: the lookup occurs in the next (IDLE) cycle and sees the written frame.
- `iREN`, `iaddr` and `ihit` must be glitch-free functions of state and registers. `ihit` in IDLE may depend combinationally on `imemaddr`/`imemREN`.

## Structure
- Shared cache package (alongside `cpu_types_pkg`):
  - `icache_frame_t` struct (valid, tag[TAG_W], data word_t).
  - `icache_state_t` enum {IDLE, FILL}.
  - `ITAG_W`/`IIDX_W` constants for the default 16 sets.
- Reuse `word_t` from `cpu_types_pkg`.
- Single module; frame array is a `SETS`-entry register array in this block. No sub-module.
- Ports group into existing `datapath_cache_if` (cache modport) and the instruction side of the cache/memory-controller interface at integration.

## Test plan
- Reset then fetch 0x0000_0040: miss. FILL drives `iaddr`=0x40. With `iwait` high 3 cycles then `iload`=0x2408_0005, `ihit`=1 and `imemload`=0x2408_0005 on the next cycle; `miss_count`=1 and `hit_count`=1.
- Refetch 0x40 repeatedly for 4 cycles: `ihit`=1 every cycle and `iREN`=0 throughout; `hit_count`=5.
- Conflict: after 0x40 is cached, fetch 0x0000_0080 (same index 0, different tag). Result is a miss, fill with 0xDEAD_BEEF, then refetch 0x40 misses again; `miss_count`=3.
- Change `imemaddr` from 0x100 to 0x104 during FILL: fill writes index for 0x100 with `iaddr`=0x100. The next cycle looks up 0x104 and misses, starting a fill with `iaddr`=0x104.
- Assert `RST` mid-FILL with `iwait`=1: next cycle shows `iREN`=0, counters 0, and the previously cached 0x40 now misses.
- `imemREN`=0 with a valid cached address: `ihit`=0, `imemload`=0, no counter change, `iREN`=0.
